// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: ALU opcodes, limits and the
// per-requester payload struct.
// No ports (package).
package types;

  // ALU operation encoding; codes 10..15 are unused and yield result 0.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam int unsigned ALU_ARB_MAX_REQ = 8;
  localparam int unsigned ALU_XLEN        = 32;

  // Operands and operation of one ALU request.
  typedef struct packed {
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    alu_op_e             op;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32 integer ALU.
// Ports: a, b (operands), op (alu_op_e), result, zero (result == 0).
module alu
  import types::*;
#(
  parameter int unsigned XLEN = ALU_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  // Operation select; shifts use only b[4:0].
  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = XLEN'($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter with its own last-grant pointer.
// Ports: clk, rst_n, req[N] (requests), advance (a grant was consumed),
//        gnt[N] (one-hot grant, combinational).
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [31:0]   idx;
  logic          found;

  // Search from last grant + 1, wrapping N-1 -> 0.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = 32'(ptr_q) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        gnt[PW'(idx)] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  // Pointer moves to the granted index only when the grant is consumed.
  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (advance && gnt[i]) ptr_d = PW'(i);
    end
  end

  // Reset pointer at N-1 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ valid/ready requesters (round-robin) and
// returns results on a single registered response channel tagged with the id.
// Ports: clk, rst_n; req_valid/req_ready/req_a/req_b/req_op per requester;
//        rsp_valid/rsp_ready/rsp_result/rsp_zero/rsp_id response channel.
// Optional: define ALU_ARB_STATS_EN to add stats_clr (in) and
//        grant_cnt[NUM_REQ][16] (out), saturating per-requester transfer counts.
module alu_arbiter
  import types::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][XLEN-1:0]     req_a,
  input  logic [NUM_REQ-1:0][XLEN-1:0]     req_b,
  input  alu_op_e [NUM_REQ-1:0]            req_op,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [XLEN-1:0]                  rsp_result,
  output logic                             rsp_zero,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic                             stats_clr,
  output logic [NUM_REQ-1:0][15:0]         grant_cnt
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  gnt_c;
  logic                accept_c;
  logic                xfer_c;
  alu_req_t            win_c;
  logic [IDW-1:0]      win_id_c;
  logic [ALU_XLEN-1:0] alu_result_c;
  logic                alu_zero_c;

  logic                rsp_valid_q,  rsp_valid_d;
  logic [XLEN-1:0]     rsp_result_q, rsp_result_d;
  logic                rsp_zero_q,   rsp_zero_d;
  logic [IDW-1:0]      rsp_id_q,     rsp_id_d;

  // Output register can take a new result when empty or being popped.
  assign accept_c  = !rsp_valid_q || rsp_ready;
  // rst_n gating keeps ready low while reset is asserted.
  assign req_ready = gnt_c & {NUM_REQ{accept_c & rst_n}};
  assign xfer_c    = |(req_valid & req_ready);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (xfer_c),
    .gnt     (gnt_c)
  );

  // Winner operand mux (one-hot grant).
  always_comb begin
    win_c    = '0;
    win_id_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        win_c.a  = ALU_XLEN'(req_a[i]);
        win_c.b  = ALU_XLEN'(req_b[i]);
        win_c.op = req_op[i];
        win_id_c = IDW'(i);
      end
    end
  end

  alu #(.XLEN(ALU_XLEN)) u_alu (
    .a      (win_c.a),
    .b      (win_c.b),
    .op     (win_c.op),
    .result (alu_result_c),
    .zero   (alu_zero_c)
  );

  // Response register: load on transfer, drain on pop, hold under backpressure.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_id_d     = rsp_id_q;
    if (accept_c) begin
      rsp_valid_d = xfer_c;
      if (xfer_c) begin
        rsp_result_d = XLEN'(alu_result_c);
        rsp_zero_d   = alu_zero_c;
        rsp_id_d     = win_id_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_id     = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;

  // Saturating per-requester transfer counters; clear beats increment.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (stats_clr) begin
      grant_cnt_d = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_cnt_q <= '0;
    else        grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (NUM_REQ=2): directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_alu_arbiter;
  import types::*;

  localparam int NR = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NR-1:0]       req_valid;
  logic [NR-1:0]       req_ready;
  logic [NR-1:0][31:0] req_a;
  logic [NR-1:0][31:0] req_b;
  alu_op_e [NR-1:0]    req_op;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_result;
  logic                rsp_zero;
  logic [0:0]          rsp_id;
`ifdef ALU_ARB_STATS_EN
  logic                stats_clr;
  logic [NR-1:0][15:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Model state
  int          m_valid, m_zero, m_id, m_last;
  logic [31:0] m_res;
  int          m_cnt [NR];
  logic [NR-1:0] held;

  alu_arbiter #(.NUM_REQ(NR), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id)
`ifdef ALU_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the opcode definitions.
  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a << sh;
      3:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:       return (a < b) ? 32'd1 : 32'd0;
      5:       return a ^ b;
      6:       return a >> sh;
      7:       return 32'($signed(a) >>> sh);
      8:       return a | b;
      9:       return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Compare process: checks every cycle, then advances the model past the next rising edge.
  initial begin
    int gi, idx;
    bit acc;
    logic [NR-1:0] exp_ready;
    held = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        m_valid = 0; m_res = '0; m_zero = 0; m_id = 0; m_last = NR - 1;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      end
      acc = (m_valid == 0) || rsp_ready;
      gi  = -1;
      if (rst_n && acc) begin
        for (int off = 1; off <= NR; off++) begin
          idx = (m_last + off) % NR;
          if (gi < 0 && req_valid[idx]) gi = idx;
        end
      end
      exp_ready = '0;
      if (gi >= 0) exp_ready[gi] = 1'b1;

      chk("rsp_valid",  32'(rsp_valid),  32'(m_valid));
      chk("rsp_result", rsp_result,      m_res);
      chk("rsp_zero",   32'(rsp_zero),   32'(m_zero));
      chk("rsp_id",     32'(rsp_id),     32'(m_id));
      chk("req_ready",  32'(req_ready),  32'(exp_ready));
`ifdef ALU_ARB_STATS_EN
      for (int i = 0; i < NR; i++) chk("grant_cnt", 32'(grant_cnt[i]), 32'(m_cnt[i]));
`endif
      held = rst_n ? (req_valid & ~exp_ready) : '0;

      if (rst_n) begin
`ifdef ALU_ARB_STATS_EN
        if (stats_clr) begin
          for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        end else if (gi >= 0 && m_cnt[gi] < 65535) begin
          m_cnt[gi]++;
        end
`endif
        if (acc) begin
          if (gi >= 0) begin
            m_res   = alu_ref(int'(req_op[gi]), req_a[gi], req_b[gi]);
            m_zero  = (m_res == 32'd0) ? 1 : 0;
            m_id    = gi;
            m_last  = gi;
            m_valid = 1;
          end else begin
            m_valid = 0;
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
    req_op[i] = alu_op_e'(4'(op));
    req_a[i]  = a;
    req_b[i]  = b;
  endtask

  // Stimulus and literal expectations
  initial begin
    int ids [4];
    logic [31:0] t5_res [4];
    int t5_op [4];
    logic [31:0] t5_a [4];
    logic [31:0] t5_b [4];
    ids = '{0, 1, 0, 1};
    t5_op  = '{7, 3, 4, 15};
    t5_a   = '{32'hF000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    t5_b   = '{32'd4, 32'd1, 32'd1, 32'd9};
    t5_res = '{32'hFF00_0000, 32'd1, 32'd0, 32'd0};

    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = '0; req_b = '0;
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    // 1: reset
    @(negedge clk); #3;
    chk("t1_valid",  32'(rsp_valid), 32'd0);
    chk("t1_ready",  32'(req_ready), 32'd0);
    chk("t1_result", rsp_result,     32'd0);
    chk("t1_id",     32'(rsp_id),    32'd0);

    // 2: single ADD
    @(negedge clk); rst_n = 1'b1; req_valid = 2'b00;
    @(negedge clk); set_req(0, 0, 32'd25, 32'd10); req_valid = 2'b01;
    #3 chk("t2_ready", 32'(req_ready), 32'd1);
    @(negedge clk); req_valid = 2'b00;
    #3;
    chk("t2_valid",  32'(rsp_valid), 32'd1);
    chk("t2_result", rsp_result,     32'd35);
    chk("t2_zero",   32'(rsp_zero),  32'd0);
    chk("t2_id",     32'(rsp_id),    32'd0);

    // 3: fairness
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    set_req(0, 1, 32'd5, 32'd5); set_req(1, 1, 32'd5, 32'd5); req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) req_valid = 2'b00;
      #3;
      chk("t3_id",     32'(rsp_id),   32'(ids[k]));
      chk("t3_result", rsp_result,    32'd0);
      chk("t3_zero",   32'(rsp_zero), 32'd1);
    end

    // 4: backpressure
    @(negedge clk); rst_n = 1'b0; req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    set_req(1, 6, 32'h8000_0000, 32'd4); req_valid = 2'b10; rsp_ready = 1'b0;
    #3 chk("t4_ready0", 32'(req_ready), 32'b10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); set_req(0, 0, 32'd1, 32'd2); req_valid = 2'b01;
      #3;
      chk("t4_hold_res",   rsp_result,      32'h0800_0000);
      chk("t4_hold_valid", 32'(rsp_valid),  32'd1);
      chk("t4_hold_ready", 32'(req_ready),  32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    #3;
    chk("t4_rel_ready", 32'(req_ready), 32'b01);
    chk("t4_rel_res",   rsp_result,     32'h0800_0000);
    @(negedge clk); req_valid = 2'b00;
    #3;
    chk("t4_next_res", rsp_result,   32'd3);
    chk("t4_next_id",  32'(rsp_id),  32'd0);

    // 5: signed ops and an illegal opcode
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        set_req(0, t5_op[k], t5_a[k], t5_b[k]); req_valid = 2'b01;
      end else begin
        req_valid = 2'b00;
      end
      #3;
      if (k > 0) chk("t5_result", rsp_result, t5_res[k-1]);
    end

    // 6: reset while holding a response
    @(negedge clk); set_req(0, 0, 32'd1, 32'd1); req_valid = 2'b01; rsp_ready = 1'b0;
    @(negedge clk); req_valid = 2'b00;
    #3 chk("t6_valid_pre", 32'(rsp_valid), 32'd1);
    @(negedge clk); rst_n = 1'b0;
    #1 chk("t6_valid_rst", 32'(rsp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    set_req(1, 0, 32'd2, 32'd2); req_valid = 2'b11;
    #3 chk("t6_prio", 32'(req_ready), 32'b01);
    @(negedge clk); req_valid = 2'b00;

`ifdef ALU_ARB_STATS_EN
    // Counters: 4 alternating transfers, clear-over-increment, saturation.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; req_valid = 2'b11;
    repeat (4) @(negedge clk);
    req_valid = 2'b00;
    #3;
    chk("st_cnt0", 32'(grant_cnt[0]), 32'd2);
    chk("st_cnt1", 32'(grant_cnt[1]), 32'd2);
    @(negedge clk); req_valid = 2'b01; stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0; req_valid = 2'b00;
    #3 chk("st_clr", 32'(grant_cnt[0]), 32'd0);
    @(negedge clk); req_valid = 2'b01;
    repeat (65540) @(negedge clk);
    req_valid = 2'b00;
    #3 chk("st_sat", 32'(grant_cnt[0]), 32'h0000_FFFF);
    @(negedge clk); req_valid = 2'b01; stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0; req_valid = 2'b00;
    #3 chk("st_clr_sat", 32'(grant_cnt[0]), 32'd0);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 199) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 49) == 0);
`endif
      for (int i = 0; i < NR; i++) begin
        if (!held[i]) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          set_req(i, int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom()),
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom()));
        end
      end
    end

    @(negedge clk); rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
